// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bus: upstream handshake, register-file read/write nets,
// flush and the downstream output register fields.
interface operand_fetch_if;
  localparam int unsigned XW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned OW = 6;

  logic          io_in_valid;
  logic          io_in_ready;
  logic [XW-1:0] io_in_inst;
  logic [XW-1:0] io_in_pc;
  logic [RW-1:0] io_rf_addra;
  logic [RW-1:0] io_rf_addrb;
  logic [XW-1:0] io_rf_douta;
  logic [XW-1:0] io_rf_doutb;
  logic          io_wb_we;
  logic [RW-1:0] io_wb_addr;
  logic [XW-1:0] io_wb_data;
  logic          io_flush;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [XW-1:0] io_out_pc;
  logic [OW-1:0] io_out_opcode;
  logic [OW-1:0] io_out_funct;
  logic [RW-1:0] io_out_shamt;
  logic [RW-1:0] io_out_dest;
  logic [XW-1:0] io_out_rs_val;
  logic [XW-1:0] io_out_rt_val;
  logic [XW-1:0] io_out_imm;

  modport slave (
    input  io_in_valid, io_in_inst, io_in_pc, io_rf_douta, io_rf_doutb,
           io_wb_we, io_wb_addr, io_wb_data, io_flush, io_out_ready,
    output io_in_ready, io_rf_addra, io_rf_addrb, io_out_valid, io_out_pc,
           io_out_opcode, io_out_funct, io_out_shamt, io_out_dest,
           io_out_rs_val, io_out_rt_val, io_out_imm
  );

  modport master (
    output io_in_valid, io_in_inst, io_in_pc, io_rf_douta, io_rf_doutb,
           io_wb_we, io_wb_addr, io_wb_data, io_flush, io_out_ready,
    input  io_in_ready, io_rf_addra, io_rf_addrb, io_out_valid, io_out_pc,
           io_out_opcode, io_out_funct, io_out_shamt, io_out_dest,
           io_out_rs_val, io_out_rt_val, io_out_imm
  );
endinterface

// File: rtl/operand_fetch.sv
// MIPS decode/operand-read stage: register-file read with write-port bypass,
// busy-bit scoreboard for RAW/WAW stalls, and a one-entry output register.
module operand_fetch #(
  parameter bit BYPASS_EN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  operand_fetch_if.slave bus
);
  localparam int unsigned XW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned OW = 6;

  logic [OW-1:0] opcode, funct;
  logic [RW-1:0] rs, rt, rd, shamt, dest;
  logic [15:0]   imm16;
  logic [XW-1:0] imm, rs_val, rt_val;
  logic          hit_rs, hit_rt, hazard, in_ready, accept;
  logic [XW-1:0] busy, busy_nxt;

  logic          out_valid;
  logic [XW-1:0] out_pc, out_rs_val, out_rt_val, out_imm;
  logic [OW-1:0] out_opcode, out_funct;
  logic [RW-1:0] out_shamt, out_dest;

  assign opcode = bus.io_in_inst[31:26];
  assign rs     = bus.io_in_inst[25:21];
  assign rt     = bus.io_in_inst[20:16];
  assign rd     = bus.io_in_inst[15:11];
  assign shamt  = bus.io_in_inst[10:6];
  assign funct  = bus.io_in_inst[5:0];
  assign imm16  = bus.io_in_inst[15:0];

  assign bus.io_rf_addra = rs;
  assign bus.io_rf_addrb = rt;

  // Destination register; 0 means the instruction writes nothing.
  always_comb begin
    dest = '0;
    if (opcode == 6'h00) begin
      dest = (funct == 6'h08) ? RW'(0) : rd;
    end else if ((opcode >= 6'h08 && opcode <= 6'h0F) ||
                 (opcode >= 6'h20 && opcode <= 6'h25)) begin
      dest = rt;
    end else if (opcode == 6'h03) begin
      dest = RW'(31);
    end
  end

  always_comb begin
    imm = {{16{imm16[15]}}, imm16};
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: imm = {16'h0000, imm16};
      6'h0F:               imm = {imm16, 16'h0000};
      default:             ;
    endcase
  end

  assign hit_rs = BYPASS_EN && bus.io_wb_we && (bus.io_wb_addr == rs) && (rs != '0);
  assign hit_rt = BYPASS_EN && bus.io_wb_we && (bus.io_wb_addr == rt) && (rt != '0);

  assign rs_val = (rs == '0) ? '0 : (hit_rs ? bus.io_wb_data : bus.io_rf_douta);
  assign rt_val = (rt == '0) ? '0 : (hit_rt ? bus.io_wb_data : bus.io_rf_doutb);

  // A same-cycle write to dest retires the older producer, so no WAW stall.
  assign hazard = (busy[rs] && !hit_rs) ||
                  (busy[rt] && !hit_rt) ||
                  ((dest != '0) && busy[dest] &&
                   !(bus.io_wb_we && (bus.io_wb_addr == dest)));

  assign in_ready = rst_n && !bus.io_flush && !hazard && (!out_valid || bus.io_out_ready);
  assign accept   = bus.io_in_valid && in_ready;
  assign bus.io_in_ready = in_ready;

  // Scoreboard update: write-port clear, flush clear, then accept set wins.
  always_comb begin
    busy_nxt = busy;
    if (bus.io_wb_we) busy_nxt[bus.io_wb_addr] = 1'b0;
    if (bus.io_flush && out_valid && (out_dest != '0)) busy_nxt[out_dest] = 1'b0;
    if (accept && (dest != '0)) busy_nxt[dest] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_opcode <= '0;
      out_funct  <= '0;
      out_shamt  <= '0;
      out_dest   <= '0;
      out_rs_val <= '0;
      out_rt_val <= '0;
      out_imm    <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_pc     <= bus.io_in_pc;
      out_opcode <= opcode;
      out_funct  <= funct;
      out_shamt  <= shamt;
      out_dest   <= dest;
      out_rs_val <= rs_val;
      out_rt_val <= rt_val;
      out_imm    <= imm;
    end else if (out_valid && (bus.io_out_ready || bus.io_flush)) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.io_out_valid  = out_valid;
  assign bus.io_out_pc     = out_pc;
  assign bus.io_out_opcode = out_opcode;
  assign bus.io_out_funct  = out_funct;
  assign bus.io_out_shamt  = out_shamt;
  assign bus.io_out_dest   = out_dest;
  assign bus.io_out_rs_val = out_rs_val;
  assign bus.io_out_rt_val = out_rt_val;
  assign bus.io_out_imm    = out_imm;
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-read stage placed directly upstream of the 32x32 register file's read ports.
- Accepts an instruction word and PC over a valid/ready handshake and drives the read addresses (rs, rt).
- Captures operands, with bypass from the write port, into an output pipeline register alongside decoded fields and the extended immediate.
- Keeps a busy-bit scoreboard of pending destination registers and stalls on RAW/WAW hazards.

Parameters:
BYPASS_EN, 1, 1 = forward same-cycle write-port data to operands; 0 = stall until the write has landed.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
io_in_valid  input  1  instruction offered
io_in_ready  output  1  stage accepts this cycle
io_in_inst  input  32  MIPS instruction word
io_in_pc  input  32  PC of the instruction
io_rf_addra  output  5  register-file read address A = inst[25:21] (rs)
io_rf_addrb  output  5  register-file read address B = inst[20:16] (rt)
io_rf_douta  input  32  register-file read data A (combinational)
io_rf_doutb  input  32  register-file read data B (combinational)
io_wb_we  input  1  write-port enable (same net as register-file write enable)
io_wb_addr  input  5  write-port address
io_wb_data  input  32  write-port data
io_flush  input  1  discard the held output instruction
io_out_valid  output  1  output register holds an instruction
io_out_ready  input  1  downstream accepts
io_out_pc  output  32  latched PC
io_out_opcode  output  6  inst[31:26]
io_out_funct  output  6  inst[5:0]
io_out_shamt  output  5  inst[10:6]
io_out_dest  output  5  destination register; 0 = no write
io_out_rs_val  output  32  rs operand
io_out_rt_val  output  32  rt operand
io_out_imm  output  32  extended immediate

Behaviour:
- Reset (rst_n low, async):
  - io_out_valid = 0; all out_* data fields = 0.
  - busy[31:0] = 0.
  - io_in_ready is low while rst_n is low.
- Read addresses are a combinational function of io_in_inst, independent of io_in_valid.
- Dest decode:
  - opcode 0x00: rd, except funct 0x08 (JR) → 0.
  - opcodes 0x08–0x0F and 0x20–0x25: rt.
  - opcode 0x03 (JAL): 31.
  - all others: 0.
- Immediate:
  - opcodes 0x0C/0x0D/0x0E: zero-extended imm16.
  - opcode 0x0F: imm16 << 16.
  - all others: sign-extended imm16.
- Bypass hit for source s: BYPASS_EN && io_wb_we && io_wb_addr == s && s != 0.
  - On a hit, the operand is io_wb_data; otherwise it is io_rf_dout.
  - Register 0 always reads 0, regardless of rf data.
- Hazard (both rs and rt are always checked, conservatively):
  - busy[rs] && !hit(rs), or
  - busy[rt] && !hit(rt), or
  - dest != 0 && busy[dest] && !(io_wb_we && io_wb_addr == dest).
- Handshake:
  - io_in_ready = rst_n && !io_flush && !hazard && (!io_out_valid || io_out_ready).
  - Accept = io_in_valid && io_in_ready.
  - On accept, the output register loads all fields next edge and io_out_valid = 1 (latency 1 cycle).
  - If io_out_valid && io_out_ready without an accept, io_out_valid → 0.
  - Back-to-back accepts are allowed at one per cycle.
- Scoreboard, per edge:
  - Clear busy[io_wb_addr] when io_wb_we.
  - Set busy[dest] when accept and dest != 0.
  - Set has priority over clear for the same index.
  - busy[0] is never set.
- Flush:
  - If io_out_valid, the held instruction is dropped: io_out_valid → 0, and busy[io_out_dest] is cleared (if nonzero), unless the same-cycle write-port clear already covers it.
  - io_in_ready = 0 during flush, so no accept happens in the flush cycle.
  - Flush with io_out_valid = 0 has no effect.
- Output fields hold stable while io_out_valid && !io_out_ready.
- Reset asserted mid-operation: state clears immediately; any in-flight handshake is lost.

Test Plan:
- Reset, then ADDI $8,$0,-3 (0x2008FFFD) with rf A = 0 → next cycle io_out_valid=1, dest=8, imm=0xFFFFFFFD, rs_val=0; busy[8]=1.
- Next offer ADD $9,$8,$8 (0x01084820) with busy[8] set and no write → io_in_ready=0 held. Then assert io_wb_we, addr=8, data=0x1234 → accepted that cycle; rs_val=rt_val=0x1234 (BYPASS_EN=1); busy[8]=0, busy[9]=1.
- Repeat the previous case with BYPASS_EN=0 → acceptance occurs one cycle after the write, with operands taken from the rf data.
- ORI $3,$2,0x8001 → imm=0x00008001. LUI $3,0xABCD → imm=0xABCD0000. JR $31 → dest=0, busy unchanged.
- io_out_ready=0 for 3 cycles with an output held → fields stable, io_in_ready=0. Then assert io_flush → io_out_valid=0 next edge and the held dest's busy bit cleared.
- Drop rst_n asynchronously between edges while io_out_valid=1 and busy[5]=1 → io_out_valid=0 and busy=0 immediately, without waiting for clk.
